// File: rtl/mult_fu_pipe_pkg.sv
// Shared types for the pipelined multiply functional unit.
package sys_defs;

    localparam int XLEN          = 32;
    localparam int ROB_CNT_WIDTH = 5;
    localparam int PRN_WIDTH     = 6;
    localparam int MULT_STAGES   = 4;

    typedef logic [ROB_CNT_WIDTH-1:0] ROBN;
    typedef logic [PRN_WIDTH-1:0]     PRN;
    typedef logic [XLEN-1:0]          DATA;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } MULT_FUNC;

    // Result handed to the CDB arbiter.
    typedef struct packed {
        ROBN robn;
        PRN  dest_prn;
        DATA result;
    } FU_MULT_PACKET;

    // Contents of one pipeline stage. mcand is pre-shifted into position for
    // the slice the next stage consumes; mplier holds the not-yet-consumed
    // low multiplier bits (shifted down), msign is bit 32 of the extended rs2.
    typedef struct packed {
        logic        valid;
        MULT_FUNC    func;
        ROBN         robn;
        PRN          dest_prn;
        logic [65:0] mcand;
        logic [31:0] mplier;
        logic        msign;
        logic [65:0] psum;
    } MULT_STAGE_PACKET;

endpackage

// File: rtl/mult_fu_pipe_stage.sv
// One elastic multiply stage: accumulates W multiplier bits into the partial
// sum and registers the result when the downstream stage can take it.
module mult_stage
    import sys_defs::*;
#(
    parameter int W    = 8,
    parameter bit LAST = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  MULT_STAGE_PACKET in_pkt,
    output MULT_STAGE_PACKET out_q
);

    MULT_STAGE_PACKET out_d;
    logic [65:0]      pp;
    logic [65:0]      mcand_nx;

    // Partial product for this slice; the last stage also applies the
    // multiplier sign bit as a -mcand*2^32 correction.
    always_comb begin
        out_d      = in_pkt;
        pp         = in_pkt.mcand * 66'(in_pkt.mplier[W-1:0]);
        mcand_nx   = in_pkt.mcand << W;
        out_d.psum = in_pkt.psum + pp;
        if (LAST && in_pkt.msign)
            out_d.psum = out_d.psum - mcand_nx;
        out_d.mcand  = mcand_nx;
        out_d.mplier = in_pkt.mplier >> W;
    end

    // Squash kills the valid bit; otherwise load when allowed, else hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            out_q <= '0;
        else if (flush)
            out_q.valid <= 1'b0;
        else if (load)
            out_q <= out_d;
    end

endmodule

// File: rtl/mult_fu_pipe.sv
// Pipelined RV32M multiply unit with elastic, bubble-collapsing stages that
// holds its result at the output until the CDB accepts it.
module mult_fu_pipe
    import sys_defs::*;
#(
    parameter int NUM_STAGES = MULT_STAGES,
    parameter int XLEN       = sys_defs::XLEN
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [XLEN-1:0]          issue_rs1,
    input  logic [XLEN-1:0]          issue_rs2,
    input  MULT_FUNC                 issue_func,
    input  logic [ROB_CNT_WIDTH-1:0] issue_robn,
    input  logic [PRN_WIDTH-1:0]     issue_dest_prn,
    output logic                     issue_ready,
    input  logic                     squash,
    input  logic                     mult_avail,
    output logic                     mult_prepared,
    output FU_MULT_PACKET            mult_packet
);

    localparam int W = 32 / NUM_STAGES;

    MULT_STAGE_PACKET        issue_pkt;
    MULT_STAGE_PACKET        st_in [NUM_STAGES];
    MULT_STAGE_PACKET        st_q  [NUM_STAGES];
    logic [NUM_STAGES-1:0]   vld;
    logic [NUM_STAGES:0]     stage_ready;
    logic [32:0]             a33;
    logic [32:0]             b33;

    // Operand extension: rs1 is unsigned only for MULHU, rs2 is signed only
    // for MUL and MULH.
    always_comb begin
        a33 = (issue_func == MULHU) ? {1'b0, issue_rs1} : {issue_rs1[31], issue_rs1};
        b33 = (issue_func == MUL || issue_func == MULH) ? {issue_rs2[31], issue_rs2}
                                                        : {1'b0, issue_rs2};
        issue_pkt          = '0;
        issue_pkt.valid    = issue_valid;
        issue_pkt.func     = issue_func;
        issue_pkt.robn     = issue_robn;
        issue_pkt.dest_prn = issue_dest_prn;
        issue_pkt.mcand    = {{33{a33[32]}}, a33};
        issue_pkt.mplier   = b33[31:0];
        issue_pkt.msign    = b33[32];
    end

    // Backward ready chain: a stage can load if it is empty or its
    // successor is moving, so bubbles never block issue.
    always_comb begin
        stage_ready             = '0;
        stage_ready[NUM_STAGES] = mult_avail;
        for (int k = NUM_STAGES - 1; k >= 0; k--)
            stage_ready[k] = ~vld[k] | stage_ready[k+1];
    end

    generate
        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign st_in[k] = issue_pkt;
            end else begin : g_mid
                assign st_in[k] = st_q[k-1];
            end
            assign vld[k] = st_q[k].valid;

            mult_stage #(
                .W    (W),
                .LAST (k == NUM_STAGES - 1)
            ) u_stage (
                .clock  (clock),
                .reset  (reset),
                .flush  (squash),
                .load   (stage_ready[k]),
                .in_pkt (st_in[k]),
                .out_q  (st_q[k])
            );
        end
    endgenerate

    assign issue_ready   = stage_ready[0];
    assign mult_prepared = vld[NUM_STAGES-1];

    // Output packet from the last stage, forced to zero when it is empty.
    always_comb begin
        mult_packet = '0;
        if (vld[NUM_STAGES-1]) begin
            mult_packet.robn     = st_q[NUM_STAGES-1].robn;
            mult_packet.dest_prn = st_q[NUM_STAGES-1].dest_prn;
            mult_packet.result   = (st_q[NUM_STAGES-1].func == MUL)
                                   ? st_q[NUM_STAGES-1].psum[31:0]
                                   : st_q[NUM_STAGES-1].psum[63:32];
        end
    end

endmodule
